parallel_in_serial_out_8_bits: RTL and testbench

Parallel-in, serial-out (PISO) shift register. It captures a WIDTH-bit parallel word on a load cycle and shifts it out one bit per clock, MSB first by default. It sits at the boundary between a parallel datapath and a single-wire serial transmitter such as a UART, SPI or custom link serialiser. Side-band status outputs tell the consumer how many valid bits remain and when the last bit is on the wire.

---
 rtl/parallel_in_serial_out_8_bits_pkg.sv | 7 +
 rtl/parallel_in_serial_out_8_bits_bit_counter.sv | 26 ++
 rtl/parallel_in_serial_out_8_bits.sv | 40 ++++
 tb/tb_parallel_in_serial_out_8_bits.sv | 103 ++++++++++
 4 files changed

// File: rtl/parallel_in_serial_out_8_bits_pkg.sv
// parallel_in_serial_out_8_bits_pkg: shared counter-width helper and default fill bit for the PISO
package parallel_in_serial_out_8_bits_pkg;
   localparam logic PISO_FILL_BIT = 1'b0;
   function automatic int piso_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction
endpackage

// File: rtl/parallel_in_serial_out_8_bits_bit_counter.sv
// piso_bit_counter: saturating down-counter of bits remaining, reloaded to WIDTH on every load
module piso_bit_counter
   import parallel_in_serial_out_8_bits_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = piso_cnt_w(WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_in,
   output logic [CW-1:0] bits_left_out,
   output logic          data_valid_out,
   output logic          last_bit_out
);
   logic [CW-1:0] count_q, count_d;
   always_comb begin
      count_d = load_in ? CW'(WIDTH) : (count_q != '0 ? count_q - CW'(1) : '0);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end
   assign bits_left_out  = count_q;
   assign data_valid_out = count_q != '0;
   assign last_bit_out   = count_q == CW'(1);
endmodule

// File: rtl/parallel_in_serial_out_8_bits.sv
// parallel_in_serial_out_8_bits: parallel-load shift register serialising one bit per clock
module parallel_in_serial_out_8_bits
   import parallel_in_serial_out_8_bits_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic FILL_BIT  = PISO_FILL_BIT
) (
   input  logic                         Clk_In,
   input  logic                         Reset_In,
   input  logic                         Load_Shiftb_In,
   input  logic [WIDTH-1:0]             Parallel_Data_In,
   output logic                         Serial_Data_Out,
   output logic [WIDTH-1:0]             PISO_Shift_Register,
   output logic [piso_cnt_w(WIDTH)-1:0] Bits_Left_Out,
   output logic                         Data_Valid_Out,
   output logic                         Last_Bit_Out
);
   logic [WIDTH-1:0] shift_q, shift_d;
   // Shifting continues after the frame ends, so an idle register drains to FILL_BIT.
   always_comb begin
      shift_d = Load_Shiftb_In ? Parallel_Data_In :
                MSB_FIRST      ? {shift_q[WIDTH-2:0], FILL_BIT} :
                                 {FILL_BIT, shift_q[WIDTH-1:1]};
   end
   always_ff @(posedge Clk_In or negedge Reset_In) begin
      if (!Reset_In) shift_q <= '0;
      else           shift_q <= shift_d;
   end
   assign Serial_Data_Out     = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
   assign PISO_Shift_Register = shift_q;
   piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk           (Clk_In),
      .rst_n         (Reset_In),
      .load_in       (Load_Shiftb_In),
      .bits_left_out (Bits_Left_Out),
      .data_valid_out(Data_Valid_Out),
      .last_bit_out  (Last_Bit_Out)
   );
endmodule

// File: tb/tb_parallel_in_serial_out_8_bits.sv
// tb_parallel_in_serial_out_8_bits: directed checks of MSB-first and LSB-first PISO instances
module tb_parallel_in_serial_out_8_bits;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load = 1'b0;
   logic [7:0] pdata = 8'h00;
   logic       m_ser, m_valid, m_last, l_ser, l_valid, l_last;
   logic [7:0] m_reg, l_reg;
   logic [3:0] m_bl, l_bl;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   parallel_in_serial_out_8_bits dut_msb (
      .Clk_In(clk), .Reset_In(rst_n), .Load_Shiftb_In(load), .Parallel_Data_In(pdata),
      .Serial_Data_Out(m_ser), .PISO_Shift_Register(m_reg), .Bits_Left_Out(m_bl),
      .Data_Valid_Out(m_valid), .Last_Bit_Out(m_last)
   );
   parallel_in_serial_out_8_bits #(.MSB_FIRST(1'b0)) dut_lsb (
      .Clk_In(clk), .Reset_In(rst_n), .Load_Shiftb_In(load), .Parallel_Data_In(pdata),
      .Serial_Data_Out(l_ser), .PISO_Shift_Register(l_reg), .Bits_Left_Out(l_bl),
      .Data_Valid_Out(l_valid), .Last_Bit_Out(l_last)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input logic ld, input logic [7:0] d);
      load  = ld;
      pdata = d;
      @(posedge clk);
      #1;
   endtask
   task automatic chk_m(input string tag, input logic [7:0] r, input logic s, input logic [3:0] bl,
                        input logic v, input logic lst);
      chk({tag, " reg"}, 32'(m_reg), 32'(r));
      chk({tag, " ser"}, 32'(m_ser), 32'(s));
      chk({tag, " bl"}, 32'(m_bl), 32'(bl));
      chk({tag, " valid"}, 32'(m_valid), 32'(v));
      chk({tag, " last"}, 32'(m_last), 32'(lst));
   endtask
   logic [7:0] a_reg [6]  = '{8'h6D, 8'hDA, 8'hB4, 8'h68, 8'hD0, 8'hA0};
   logic       a_ser [6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [7:0] b_reg [9]  = '{8'hA1, 8'h42, 8'h84, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
   logic       b_ser [9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [7:0] c_reg [8]  = '{8'h6D, 8'h36, 8'h1B, 8'h0D, 8'h06, 8'h03, 8'h01, 8'h00};
   logic       c_ser [8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_m("reset", 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      cyc(1'b1, 8'h5A);
      #2 rst_n = 1'b0;
      #1;
      chk_m("async_reset", 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(1'b1, 8'h6D);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) cyc(1'b0, 8'h00);
         chk_m($sformatf("a%0d", k), a_reg[k], a_ser[k], 4'(8 - k), 1'b1, 1'b0);
      end
      cyc(1'b1, 8'hA1);
      for (int k = 0; k < 9; k++) begin
         if (k > 0) cyc(1'b0, 8'h00);
         chk_m($sformatf("b%0d", k), b_reg[k], b_ser[k], 4'(8 - k), k != 8, k == 7);
      end
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 8'h00);
         chk_m($sformatf("under%0d", k), 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
      end
      cyc(1'b1, 8'hFF);
      cyc(1'b0, 8'h00);
      cyc(1'b0, 8'h00);
      chk_m("ff_shift2", 8'hFC, 1'b1, 4'd6, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_m("mid_reset", 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(1'b1, 8'h81);
      chk_m("restart", 8'h81, 1'b1, 4'd8, 1'b1, 1'b0);
      cyc(1'b1, 8'h6D);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) cyc(1'b0, 8'h00);
         chk($sformatf("lsb%0d reg", k), 32'(l_reg), 32'(c_reg[k]));
         chk($sformatf("lsb%0d ser", k), 32'(l_ser), 32'(c_ser[k]));
         chk($sformatf("lsb%0d bl", k), 32'(l_bl), 32'(8 - k));
         chk($sformatf("lsb%0d last", k), 32'(l_last), 32'(k == 7));
      end
      cyc(1'b0, 8'h00);
      chk("lsb_done valid", 32'(l_valid), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
